// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Ports: clk, rst_n, [sync], en, clr, div_ld, div_in -> tick, sq.
//
// Each channel counts enabled cycles up to its active divisor. At the
// terminal count it emits a one-cycle tick and toggles its square
// output. A divisor of 0 behaves like 1.
//
// New divisors are staged in a pending register. While running, a staged
// value takes effect only at the wrap, so the current period always
// finishes with the old divisor. While paused, it takes effect on the
// next edge.
//
// Optional feature, guarded by the macro CLK_DIV_SYNC_EN: adds a `sync`
// input that clears every channel at once. It also applies any staged
// divisor, so channels with equal divisors tick in phase afterwards.
module clk_div_multi #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 20,
  parameter int DEF_DIV = 500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       div_ld,
  input  logic [NUM_CH*CNT_W-1:0] div_in,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       sq
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] div_q, div_d;
  logic [NUM_CH-1:0][CNT_W-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0][CNT_W-1:0] lim;
  logic [NUM_CH-1:0]            pv_q, pv_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            sq_q, sq_d;
  logic [NUM_CH-1:0]            term;
  logic [NUM_CH-1:0]            apply;
  logic                         sync_all;

`ifdef CLK_DIV_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  // Terminal count is eff_div-1. The >= compare matters only if a smaller
  // divisor is applied while paused with cnt already past the new end.
  // In that case the period ends at once instead of counting through the
  // whole counter range.
  always_comb begin
    lim  = '0;
    term = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lim[k]  = (div_q[k] == '0) ? '0 : div_q[k] - ONE;
      term[k] = (cnt_q[k] >= lim[k]);
    end
  end

  // A staged divisor is applied on sync, when paused, or at the wrap.
  // A load in the same cycle is staged after the apply, so it waits for
  // the next opportunity.
  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    sq_d   = sq_q;
    tick_d = '0;
    apply  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      apply[k] = pv_q[k] &
                 (sync_all | (~clr[k] & (~en[k] | term[k])));

      if (sync_all | clr[k]) begin
        cnt_d[k] = '0;
        sq_d[k]  = 1'b0;
      end else if (en[k]) begin
        if (term[k]) begin
          cnt_d[k]  = '0;
          tick_d[k] = 1'b1;
          sq_d[k]   = ~sq_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + ONE;
        end
      end

      if (apply[k]) begin
        div_d[k] = pend_q[k];
        pv_d[k]  = 1'b0;
      end

      if (div_ld[k]) begin
        pend_d[k] = div_in[k*CNT_W +: CNT_W];
        pv_d[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= {NUM_CH{DEF}};
      pend_q <= '0;
      pv_q   <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule
